// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 64x8 RAM, GPI/GPO ports and byte-stream boot loader on the CPU memory bus
// Holds the CPU in reset via CPU_HOLD whenever the loader owns the RAM.
module mem_responder #(
  parameter int               AW          = 6,
  parameter int               DW          = 8,
  parameter logic [AW-1:0]    IO_OUT_ADDR = 6'h3F,
  parameter logic [AW-1:0]    IO_IN_ADDR  = 6'h3E,
  parameter int               LOAD_LEN    = 64,
  parameter bit               BOOT_HOLD   = 1'b1
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic [AW-1:0] ADDR,
  input  logic          RE,
  input  logic          WE,
  input  logic [DW-1:0] WDATA,
  output logic [DW-1:0] RDATA,
  input  logic [DW-1:0] GPI,
  output logic [DW-1:0] GPO,
  input  logic          LD_START,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  output logic          LD_BUSY,
  output logic          CPU_HOLD
);

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_LOAD, S_DONE} state_t;

  localparam state_t        RESET_STATE = BOOT_HOLD ? S_WAIT : S_IDLE;
  localparam logic [AW:0]   LAST_IDX    = (AW+1)'(LOAD_LEN - 1);

  state_t         state;
  state_t         state_nxt;
  logic [AW:0]    cnt;
  logic [DW-1:0]  mem [0:(2**AW)-1];

  logic           cpu_en;
  logic           ld_wr;
  logic           cpu_wr;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    LD_READY  = 1'b0;
    LD_BUSY   = 1'b0;
    CPU_HOLD  = 1'b1;
    case (state)
      S_WAIT: begin
        if (LD_START) state_nxt = S_LOAD;
      end
      S_IDLE: begin
        CPU_HOLD = 1'b0;
        if (LD_START) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        LD_READY = 1'b1;
        LD_BUSY  = 1'b1;
        if (LD_VALID && (cnt == LAST_IDX)) state_nxt = S_DONE;
      end
      S_DONE: begin
        LD_BUSY   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  // Counter sits at zero outside LOAD, which also covers the clear on entry.
  always_ff @(posedge CLK) begin
    if (RES || (state != S_LOAD)) begin
      cnt <= '0;
    end else if (LD_VALID) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cpu_en = !CPU_HOLD;
  assign ld_wr  = !RES && (state == S_LOAD) && LD_VALID;
  assign cpu_wr = !RES && cpu_en && WE && (ADDR != IO_OUT_ADDR) && (ADDR != IO_IN_ADDR);

  // Loader and CPU writes are exclusive: the CPU is always held during LOAD.
  always_ff @(posedge CLK) begin
    if (ld_wr) begin
      mem[cnt[AW-1:0]] <= LD_DATA;
    end else if (cpu_wr) begin
      mem[ADDR] <= WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      RDATA <= '0;
      GPO   <= '0;
    end else if (cpu_en) begin
      if (RE) begin
        if (ADDR == IO_IN_ADDR) begin
          RDATA <= GPI;
        end else if (ADDR == IO_OUT_ADDR) begin
          RDATA <= GPO;
        end else begin
          RDATA <= mem[ADDR];
        end
      end
      if (WE && (ADDR == IO_OUT_ADDR)) begin
        GPO <= WDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder with a read-response scoreboard
module tb_mem_responder;

  logic       CLK;
  logic       RES;
  logic [5:0] ADDR;
  logic       RE;
  logic       WE;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic [7:0] GPI;
  logic [7:0] GPO;
  logic       LD_START;
  logic       LD_VALID;
  logic [7:0] LD_DATA;
  logic       LD_READY;
  logic       LD_BUSY;
  logic       CPU_HOLD;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [0:63];
  logic [7:0] model_gpo;
  logic [7:0] last_rdata;
  logic [7:0] exp_q [$];

  mem_responder dut (
    .CLK      (CLK),
    .RES      (RES),
    .ADDR     (ADDR),
    .RE       (RE),
    .WE       (WE),
    .WDATA    (WDATA),
    .RDATA    (RDATA),
    .GPI      (GPI),
    .GPO      (GPO),
    .LD_START (LD_START),
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_READY (LD_READY),
    .LD_BUSY  (LD_BUSY),
    .CPU_HOLD (CPU_HOLD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] model_read(input logic [5:0] a);
    if (a == 6'h3E) return GPI;
    if (a == 6'h3F) return model_gpo;
    return model_mem[a];
  endfunction

  task automatic cpu_read(input logic [5:0] a);
    exp_q.push_back(model_read(a));
    ADDR = a;
    RE   = 1'b1;
    tick();
    RE = 1'b0;
    last_rdata = exp_q.pop_front();
    check($sformatf("rd_%02h", a), RDATA, last_rdata);
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    ADDR  = a;
    WDATA = d;
    WE    = 1'b1;
    tick();
    WE = 1'b0;
    if (a == 6'h3F) model_gpo = d;
    else if (a != 6'h3E) model_mem[a] = d;
  endtask

  task automatic cpu_read_write(input logic [5:0] a, input logic [7:0] d);
    exp_q.push_back(model_read(a));
    ADDR  = a;
    WDATA = d;
    RE    = 1'b1;
    WE    = 1'b1;
    tick();
    RE = 1'b0;
    WE = 1'b0;
    if (a == 6'h3F) model_gpo = d;
    else if (a != 6'h3E) model_mem[a] = d;
    last_rdata = exp_q.pop_front();
    check($sformatf("rmw_%02h", a), RDATA, last_rdata);
  endtask

  // Streams n bytes base+i; a full load (n==64) also checks DONE and release.
  task automatic do_load(input logic [7:0] base, input int n, input bit gaps);
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
    check("hold_in_load", {7'd0, CPU_HOLD}, 8'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i == 5 || i == 40)) begin
        if (i == 40) begin
          ADDR  = 6'h20;
          WDATA = 8'hFF;
          RE    = 1'b1;
          WE    = 1'b1;
        end
        LD_VALID = 1'b0;
        tick();
        RE = 1'b0;
        WE = 1'b0;
        if (i == 40) check("held_rdata", RDATA, last_rdata);
      end
      check($sformatf("ld_ready_%0d", i), {7'd0, LD_READY}, 8'd1);
      LD_VALID = 1'b1;
      LD_DATA  = base + 8'(i);
      tick();
      model_mem[i] = base + 8'(i);
    end
    LD_VALID = 1'b0;
    if (n == 64) begin
      check("done_ready", {7'd0, LD_READY}, 8'd0);
      check("done_busy",  {7'd0, LD_BUSY},  8'd1);
      check("done_hold",  {7'd0, CPU_HOLD}, 8'd1);
      tick();
      check("idle_busy",  {7'd0, LD_BUSY},  8'd0);
      check("idle_hold",  {7'd0, CPU_HOLD}, 8'd0);
    end
  endtask

  initial begin
    RES = 1'b1; ADDR = '0; RE = 1'b0; WE = 1'b0; WDATA = '0; GPI = 8'h00;
    LD_START = 1'b0; LD_VALID = 1'b0; LD_DATA = '0;
    model_gpo = 8'h00;
    last_rdata = 8'h00;
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;

    tick();
    tick();
    RES = 1'b0;
    check("rst_rdata", RDATA, 8'h00);
    check("rst_gpo",   GPO,   8'h00);
    check("rst_hold",  {7'd0, CPU_HOLD}, 8'd1);
    check("rst_busy",  {7'd0, LD_BUSY},  8'd0);
    check("rst_ready", {7'd0, LD_READY}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("wait_hold", {7'd0, CPU_HOLD}, 8'd1);
    end

    do_load(8'h80, 64, 1'b1);
    cpu_read(6'h07);
    cpu_read(6'h20);

    LD_VALID = 1'b1;
    LD_DATA  = 8'hEE;
    tick();
    tick();
    LD_VALID = 1'b0;
    cpu_read(6'h00);

    cpu_write(6'h10, 8'h5A);
    cpu_read(6'h10);
    cpu_read_write(6'h10, 8'h33);
    cpu_read(6'h10);

    cpu_write(6'h3F, 8'hC3);
    check("gpo_write", GPO, 8'hC3);
    cpu_read(6'h3F);
    check("ram3f_kept", dut.mem[63], model_mem[63]);

    GPI = 8'h96;
    cpu_read(6'h3E);
    cpu_write(6'h3E, 8'h11);
    check("gpo_after_gpi_wr", GPO, 8'hC3);
    check("ram3e_kept", dut.mem[62], model_mem[62]);
    cpu_read(6'h3E);

    do_load(8'h40, 10, 1'b0);
    RES = 1'b1;
    tick();
    RES = 1'b0;
    model_gpo = 8'h00;
    last_rdata = 8'h00;
    check("midrst_hold",  {7'd0, CPU_HOLD}, 8'd1);
    check("midrst_busy",  {7'd0, LD_BUSY},  8'd0);
    check("midrst_ready", {7'd0, LD_READY}, 8'd0);
    check("midrst_cnt",   {1'b0, dut.cnt},  8'd0);
    check("midrst_gpo",   GPO, 8'h00);
    for (int i = 0; i < 10; i++) check($sformatf("kept_%0d", i), dut.mem[i], model_mem[i]);
    check("kept_10", dut.mem[10], model_mem[10]);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_wait_hold", {7'd0, CPU_HOLD}, 8'd1);
    end

    do_load(8'h20, 64, 1'b0);
    cpu_read(6'h00);
    cpu_read(6'h09);
    cpu_read(6'h20);
    cpu_read(6'h3D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
